// File: rtl/tile_skew_feeder.sv
// Re-times 256-bit row words into a diagonal wavefront: lane k is delayed k+1 cycles, then a drain pulses tile_done.
// Optional SKEW_ZERO_BUBBLE_EN forces invalid lanes to carry zero data; out_ready low freezes every register.
module tile_skew_feeder #(
  parameter int DATA_WIDTH = 256,
  parameter int NUM_BITS   = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  input  logic [DATA_WIDTH-1:0]               in_data,
  input  logic                                in_last,
  output logic                                in_ready,
  input  logic                                out_ready,
  output logic [DATA_WIDTH-1:0]               out_data,
  output logic [DATA_WIDTH/NUM_BITS-1:0]      out_lane_valid,
  output logic                                tile_done,
  output logic                                busy
);

  localparam int LANES = DATA_WIDTH / NUM_BITS;
  localparam int CW    = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   drain_cnt_q, drain_cnt_d;
  logic            accept;

  assign in_ready  = out_ready && (state_q != DRAIN);
  assign accept    = in_valid && in_ready;
  assign tile_done = (state_q == DRAIN) && (drain_cnt_q == '0);
  assign busy      = (state_q != IDLE);

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    if (out_ready) begin
      unique case (state_q)
        IDLE, STREAM: begin
          if (accept) begin
            if (in_last) begin
              state_d     = DRAIN;
              drain_cnt_d = CW'(LANES - 1);
            end else begin
              state_d = STREAM;
            end
          end
        end
        DRAIN: begin
          if (drain_cnt_q == '0) begin
            state_d = IDLE;
          end else begin
            drain_cnt_d = drain_cnt_q - 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  // One shift register per lane; lane k has k+1 stages and its last stage drives the output.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [NUM_BITS-1:0] dat_q [k+1];
    logic [NUM_BITS-1:0] dat_d [k+1];
    logic [k:0]          vld_q, vld_d;
    logic [NUM_BITS-1:0] lane_in;

`ifdef SKEW_ZERO_BUBBLE_EN
    assign lane_in = accept ? in_data[k*NUM_BITS +: NUM_BITS] : '0;
`else
    assign lane_in = in_data[k*NUM_BITS +: NUM_BITS];
`endif

    always_comb begin
      vld_d = vld_q;
      for (int i = 0; i <= k; i++) begin
        dat_d[i] = dat_q[i];
      end
      if (out_ready) begin
        vld_d[0] = accept;
        dat_d[0] = lane_in;
        for (int s = 1; s <= k; s++) begin
          vld_d[s] = vld_q[s-1];
          dat_d[s] = dat_q[s-1];
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q <= '0;
        for (int i = 0; i <= k; i++) begin
          dat_q[i] <= '0;
        end
      end else begin
        vld_q <= vld_d;
        for (int i = 0; i <= k; i++) begin
          dat_q[i] <= dat_d[i];
        end
      end
    end

    assign out_data[k*NUM_BITS +: NUM_BITS] = dat_q[k];
    assign out_lane_valid[k]                = vld_q[k];
  end

endmodule

// File: tb/tb_tile_skew_feeder.sv
// Directed + randomized bench for tile_skew_feeder against an advance-indexed history model.
module tb_tile_skew_feeder;

  localparam int DW = 256;
  localparam int NB = 8;
  localparam int L  = DW / NB;
  localparam int HMAX = 8192;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic          in_ready;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [L-1:0]  out_lane_valid;
  logic          tile_done;
  logic          busy;

  tile_skew_feeder #(.DATA_WIDTH(DW), .NUM_BITS(NB)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .out_ready(out_ready), .out_data(out_data),
    .out_lane_valid(out_lane_valid), .tile_done(tile_done), .busy(busy)
  );

  always #5 clk = ~clk;

  // Model: every advancing edge since reset gets an entry; lane k on the output
  // shows the entry written k+1 advances ago.
  bit            hist_vld [HMAX];
  logic [DW-1:0] hist_dat [HMAX];
  int            adv;
  int            last_idx;
  bit            in_tile;
  bit            exp_rdy;

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  function automatic bit model_drain();
    return (last_idx >= 0) && (adv - 1 - last_idx <= L - 1);
  endfunction

  task automatic check_outputs();
    logic [DW-1:0] exp_dat, mask;
    logic [L-1:0]  exp_vld;
    int idx;
    exp_dat = '0;
    mask    = '0;
    exp_vld = '0;
    for (int k = 0; k < L; k++) begin
      idx = adv - 1 - k;
      if (idx >= 0 && hist_vld[idx]) begin
        exp_vld[k] = 1'b1;
        exp_dat[k*NB +: NB] = hist_dat[idx][k*NB +: NB];
        mask[k*NB +: NB] = '1;
      end
    end
    chk("lane_valid", DW'(out_lane_valid), DW'(exp_vld));
`ifdef SKEW_ZERO_BUBBLE_EN
    chk("out_data", out_data, exp_dat);
`else
    chk("out_data", out_data & mask, exp_dat);
`endif
    chk("tile_done", DW'(tile_done),
        DW'((last_idx >= 0) && (adv - 1 - last_idx == L - 1)));
    chk("busy", DW'(busy), DW'(in_tile || model_drain()));
    exp_rdy = out_ready && !model_drain();
    chk("in_ready", DW'(in_ready), DW'(exp_rdy));
  endtask

  task automatic cyc(input bit v, input logic [DW-1:0] d, input bit l,
                     input bit ordy, input bit r, output bit acc);
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    out_ready = ordy;
    rst       = r;
    @(negedge clk);
    check_outputs();
    acc = !r && v && exp_rdy;
    @(posedge clk);
    if (r) begin
      adv      = 0;
      last_idx = -1;
      in_tile  = 1'b0;
    end else if (ordy) begin
      if (adv < HMAX) begin
        hist_vld[adv] = acc;
        hist_dat[adv] = d;
      end
      if (acc) begin
        if (l) begin
          last_idx = adv;
          in_tile  = 1'b0;
        end else begin
          in_tile = 1'b1;
        end
      end
      adv++;
    end
    #1;
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) cyc(1'b0, rand_word(), 1'b0, 1'b1, 1'b0, acc);
  endtask

  task automatic send(input logic [DW-1:0] d, input bit l);
    bit acc = 1'b0;
    int n = 0;
    while (!acc && n < 200) begin
      cyc(1'b1, d, l, 1'b1, 1'b0, acc);
      n++;
    end
    chk("send_accepted", DW'(acc), DW'(1));
  endtask

  initial begin
    logic [DW-1:0] w;
    bit acc, l, pending;
    adv = 0; last_idx = -1; in_tile = 1'b0; exp_rdy = 1'b0;
    rst = 1'b1; in_valid = 1'b1; in_data = rand_word(); in_last = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;

    // Reset held with a word presented: nothing may be accepted.
    for (int i = 0; i < 3; i++) cyc(1'b1, rand_word(), 1'b0, 1'b1, 1'b1, acc);
    idle(3);

    // Single-row tile, lane k = k+1.
    for (int k = 0; k < L; k++) w[k*NB +: NB] = NB'(k + 1);
    send(w, 1'b1);
    idle(36);

    // 32-row tile, row r lanes = r*2+2.
    for (int r = 0; r < L; r++) begin
      for (int k = 0; k < L; k++) w[k*NB +: NB] = NB'(r * 2 + 2);
      send(w, r == L - 1);
    end
    idle(36);

    // Stall of 5 cycles mid-tile with a word held on the input.
    for (int r = 0; r < 20; r++) begin
      w = rand_word();
      if (r == 10) begin
        for (int s = 0; s < 5; s++) cyc(1'b1, w, 1'b0, 1'b0, 1'b0, acc);
      end
      send(w, r == 19);
    end
    // Word offered during DRAIN must wait for IDLE and start the next tile.
    send(rand_word(), 1'b0);
    send(rand_word(), 1'b1);
    idle(36);

    // Bubbles inside a tile.
    send(rand_word(), 1'b0);
    idle(1);
    send(rand_word(), 1'b0);
    idle(2);
    send(rand_word(), 1'b1);
    idle(36);

    // Randomized traffic with random backpressure; words held until accepted.
    pending = 1'b0; l = 1'b0; w = '0;
    for (int i = 0; i < 600; i++) begin
      if (!pending && $urandom_range(0, 3) != 0) begin
        w = rand_word();
        l = ($urandom_range(0, 11) == 0);
        pending = 1'b1;
      end
      cyc(pending, pending ? w : rand_word(), pending ? l : 1'b0,
          $urandom_range(0, 4) != 0, 1'b0, acc);
      if (acc) pending = 1'b0;
    end
    if (pending) send(w, l);
    send(rand_word(), 1'b1);
    idle(40);

    // Reset during DRAIN aborts the tile without tile_done.
    send(rand_word(), 1'b0);
    send(rand_word(), 1'b1);
    idle(10);
    for (int i = 0; i < 2; i++) cyc(1'b0, rand_word(), 1'b0, 1'b1, 1'b1, acc);
    idle(40);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/tile_skew_feeder.md
# tile_skew_feeder

Downstream neighbour of the BRAM fetch unit: accepts the 256-bit row words the fetch unit streams out of the weight/bias/input buffers and re-times them into a diagonally skewed wavefront for the west/north edge of the 32-lane systolic array. Lane k of every accepted word is delayed k extra cycles. After the last word of a tile, the feeder drains the skew pipeline and pulses `tile_done`. A single downstream `out_ready` stalls the whole pipeline.

## Interface
- `DATA_WIDTH`, 256, width of one fetched row word; must be a multiple of `NUM_BITS`.
- `NUM_BITS`, 8, width of one quantized element (one lane).
- Derived (localparam, not overridable): `LANES = DATA_WIDTH/NUM_BITS` (32). Lane k occupies bits `[k*NUM_BITS +: NUM_BITS]`.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  fetch unit presents a row word.
- `in_data`  in  DATA_WIDTH  row word from BRAM `doutb`.
- `in_last`  in  1  qualifies `in_data` as the last row of the tile.
- `in_ready`  out  1  word accepted on the edge where `in_valid && in_ready`.
- `out_ready`  in  1  array advance enable; low freezes every register.
- `out_data`  out  DATA_WIDTH  skewed lanes toward the array.
- `out_lane_valid`  out  LANES  per-lane valid for `out_data`.
- `tile_done`  out  1  high for one advancing cycle when the last lane of the last row is on the output.
- `busy`  out  1  state ≠ IDLE.

## Operation
- Skew pipeline: lane k is a (k+1)-stage shift register of data plus a valid bit. Lane 0 has 1 stage; lane 31 has 32 stages.
- Advance: all stages shift when `out_ready` = 1. On an advancing cycle without acceptance, a bubble enters every lane (valid = 0).
- `in_ready = out_ready && state != DRAIN` (combinational).
- FSM states:
  - IDLE: on accept, go to STREAM. If `in_last` is also set, go directly to DRAIN.
  - STREAM: on an accept with `in_last`, go to DRAIN and load `drain_cnt = LANES-1`.
  - DRAIN: decrement `drain_cnt` on each advancing cycle. `tile_done` = (DRAIN && `drain_cnt == 0`). On the advancing cycle with `drain_cnt == 0`, go to IDLE.
- `in_valid` during DRAIN is not accepted. The fetch unit must hold the word.
- Bubbles inside a tile (STREAM with `in_valid` = 0) are legal and propagate as invalid lanes.
- Reset, including mid-tile: all stages, valids, `drain_cnt`, and outputs go to 0; state goes to IDLE. No `tile_done` is produced for the aborted tile.
- Reset values: `in_ready` = `out_ready`; `out_data` = 0; `out_lane_valid` = 0; `tile_done` = 0; `busy` = 0.

## Timing
- A word accepted in cycle t, with `out_ready` held high, places lane k on `out_data` in cycle t+1+k with `out_lane_valid[k]` = 1.
- If the last word is accepted in cycle t, `tile_done` is high in cycle t+LANES (t+32) and state is IDLE in cycle t+33. The next tile can be accepted in cycle t+33.
- Throughput is one row per cycle. Back-to-back tiles carry a 32-cycle gap (DRAIN).
- Each stalled cycle (`out_ready` = 0) adds one cycle to every latency above. During the stall all outputs hold their values and `tile_done` holds if already asserted.

## Configuration
- `SKEW_ZERO_BUBBLE_EN`:
  - Defined: each lane's data stage loads 0 whenever its valid is 0, so invalid lanes on `out_data` are exactly 0 (safe for MACs that ignore valid).
  - Undefined: the data stage loads `in_data` unconditionally, and invalid lanes carry don't-care data. This saves the mask logic.

## Test plan
- Reset: hold `rst` = 1 for 3 cycles with `in_valid` = 1. Required: `out_lane_valid` = 0, `busy` = 0, `tile_done` = 0, no accept recorded after release.
- Single-row tile: lane k = k+1, `in_last` = 1, accepted at t0.
  - `out_lane_valid` = one-hot bit k at cycle t0+1+k, with that lane = k+1.
  - `tile_done` at t0+32.
  - `busy` low at t0+33.
- 32-row tile: row r lane k = r*2+2 (mod 256), `out_ready` = 1 throughout.
  - At cycle t0+1+r+k, lane k = row r's value.
  - `tile_done` exactly once, 32 cycles after row 31 is accepted.
- Stall: drop `out_ready` for 5 cycles mid-tile.
  - Outputs are frozen and `in_ready` = 0.
  - All latencies shift by 5, with no lost or duplicated lanes.
- `in_valid` during DRAIN: `in_ready` = 0 and the word is not consumed. It is accepted in the first IDLE cycle and starts the next tile.
- Bubble/macro: insert a 1-cycle `in_valid` gap.
  - With `SKEW_ZERO_BUBBLE_EN`, invalid lanes read 0.
  - Without it, valid lanes still match expected values.
  - Reset asserted in DRAIN yields no `tile_done`.
